// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the two-street light codes {La,Lb} every clock and tracks the
// controller phase. It flags protocol violations with a sticky error and
// first-fault code, counts completed A->B->A rotations, and raises a
// starvation flag per street after a long run of consecutive red samples.
module traffic_light_monitor #(
    parameter int CNT_W   = 8,
    parameter int MAX_RED = 16
) (
    input  logic             clk,
    input  logic             NOT_RESET,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             starve_a,
    output logic             starve_b
);

    typedef enum logic [1:0] {
        A_GREEN  = 2'd0,
        A_YELLOW = 2'd1,
        B_GREEN  = 2'd2,
        B_YELLOW = 2'd3
    } phase_e;

    localparam logic [1:0]       L_RED   = 2'b00;
    localparam logic [1:0]       L_BAD   = 2'b11;
    localparam logic [7:0]       RED_MAX = 8'(MAX_RED);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] V_NONE     = 3'b000;
    localparam logic [2:0] V_BADCODE  = 3'b001;
    localparam logic [2:0] V_BOTH_GO  = 3'b010;
    localparam logic [2:0] V_BOTH_RED = 3'b011;
    localparam logic [2:0] V_BADSEQ   = 3'b100;

    phase_e           phase_q, phase_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [7:0]       red_a_q, red_a_d;
    logic [7:0]       red_b_q, red_b_d;
    logic             starve_a_q, starve_a_d;
    logic             starve_b_q, starve_b_d;

    logic             pat_legal_s;
    phase_e           pat_phase_s;
    logic             allowed_s;
    logic [2:0]       illegal_code_s;
    logic [2:0]       viol_code_s;

    // Decode the sampled pattern, classify it against the current phase and compute next state.
    always_comb begin
        pat_legal_s    = 1'b0;
        pat_phase_s    = A_GREEN;
        allowed_s      = 1'b0;
        illegal_code_s = V_NONE;
        viol_code_s    = V_NONE;
        phase_d        = phase_q;
        err_d          = err_q;
        err_code_d     = err_code_q;
        cycle_count_d  = cycle_count_q;
        red_a_d        = red_a_q;
        red_b_d        = red_b_q;

        case ({La, Lb})
            4'b1000: begin pat_legal_s = 1'b1; pat_phase_s = A_GREEN;  end
            4'b0100: begin pat_legal_s = 1'b1; pat_phase_s = A_YELLOW; end
            4'b0010: begin pat_legal_s = 1'b1; pat_phase_s = B_GREEN;  end
            4'b0001: begin pat_legal_s = 1'b1; pat_phase_s = B_YELLOW; end
            default: begin pat_legal_s = 1'b0; pat_phase_s = A_GREEN;  end
        endcase

        // Illegal-pattern priority: bad code, then conflicting go, then all-red.
        if ((La == L_BAD) || (Lb == L_BAD)) begin
            illegal_code_s = V_BADCODE;
        end else if ((La != L_RED) && (Lb != L_RED)) begin
            illegal_code_s = V_BOTH_GO;
        end else if ((La == L_RED) && (Lb == L_RED)) begin
            illegal_code_s = V_BOTH_RED;
        end else begin
            illegal_code_s = V_NONE;
        end

        case (phase_q)
            A_GREEN:  allowed_s = pat_legal_s && ((pat_phase_s == A_GREEN) || (pat_phase_s == A_YELLOW));
            A_YELLOW: allowed_s = pat_legal_s && (pat_phase_s == B_GREEN);
            B_GREEN:  allowed_s = pat_legal_s && ((pat_phase_s == B_GREEN) || (pat_phase_s == B_YELLOW));
            B_YELLOW: allowed_s = pat_legal_s && (pat_phase_s == A_GREEN);
            default:  allowed_s = 1'b0;
        endcase

        if (!pat_legal_s) begin
            viol_code_s = illegal_code_s;
        end else if (!allowed_s) begin
            viol_code_s = V_BADSEQ;
        end else begin
            viol_code_s = V_NONE;
        end

        // Legal patterns always set the phase (resync on a bad sequence); illegal ones hold.
        if (pat_legal_s) begin
            phase_d = pat_phase_s;
        end else begin
            phase_d = phase_q;
        end

        // Sticky first-fault capture; a clear in the same cycle as a fault loads the new code.
        if (viol_code_s != V_NONE) begin
            err_d = 1'b1;
            if (!err_q || clr_err) begin
                err_code_d = viol_code_s;
            end else begin
                err_code_d = err_code_q;
            end
        end else if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = V_NONE;
        end else begin
            err_d      = err_q;
            err_code_d = err_code_q;
        end

        if (allowed_s && (phase_q == B_YELLOW) && (cycle_count_q != CNT_MAX)) begin
            cycle_count_d = cycle_count_q + CNT_ONE;
        end else begin
            cycle_count_d = cycle_count_q;
        end

        // Red run-length counters ignore violations entirely.
        if (La != L_RED) begin
            red_a_d = 8'd0;
        end else if (red_a_q != RED_MAX) begin
            red_a_d = red_a_q + 8'd1;
        end else begin
            red_a_d = red_a_q;
        end

        if (Lb != L_RED) begin
            red_b_d = 8'd0;
        end else if (red_b_q != RED_MAX) begin
            red_b_d = red_b_q + 8'd1;
        end else begin
            red_b_d = red_b_q;
        end

        starve_a_d = (red_a_d == RED_MAX);
        starve_b_d = (red_b_d == RED_MAX);
    end

    // Phase FSM and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge NOT_RESET) begin
        if (NOT_RESET) begin
            phase_q       <= A_GREEN;
            err_q         <= 1'b0;
            err_code_q    <= V_NONE;
            cycle_count_q <= {CNT_W{1'b0}};
            red_a_q       <= 8'd0;
            red_b_q       <= 8'd0;
            starve_a_q    <= 1'b0;
            starve_b_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            cycle_count_q <= cycle_count_d;
            red_a_q       <= red_a_d;
            red_b_q       <= red_b_d;
            starve_a_q    <= starve_a_d;
            starve_b_q    <= starve_b_d;
        end
    end

    assign phase       = phase_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign cycle_count = cycle_count_q;
    assign starve_a    = starve_a_q;
    assign starve_b    = starve_b_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor (CNT_W=2, MAX_RED=16).
module tb_traffic_light_monitor;

    logic       clk;
    logic       NOT_RESET;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       clr_err;
    logic [1:0] phase;
    logic       err;
    logic [2:0] err_code;
    logic [1:0] cycle_count;
    logic       starve_a;
    logic       starve_b;

    int n_cmp;
    int n_bad;

    traffic_light_monitor #(.CNT_W(2), .MAX_RED(16)) dut (
        .clk         (clk),
        .NOT_RESET   (NOT_RESET),
        .La          (La),
        .Lb          (Lb),
        .clr_err     (clr_err),
        .phase       (phase),
        .err         (err),
        .err_code    (err_code),
        .cycle_count (cycle_count),
        .starve_a    (starve_a),
        .starve_b    (starve_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one sample and look at the outputs 1 time unit after the edge.
    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic c);
        La = a; Lb = b; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        NOT_RESET = 1'b1; La = 2'b10; Lb = 2'b00; clr_err = 1'b0;
        @(posedge clk);
        #1;
        NOT_RESET = 1'b0;
    endtask

    task automatic test_reset();
        NOT_RESET = 1'b1; La = 2'b11; Lb = 2'b11; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", err); end
        n_cmp++; if (err_code !== 3'b000) begin n_bad++; $display("FAIL reset_code got %b want 000", err_code); end
        n_cmp++; if (cycle_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cycle_count); end
        n_cmp++; if ({starve_a, starve_b} !== 2'b00) begin n_bad++; $display("FAIL reset_starve got %b want 00", {starve_a, starve_b}); end
    endtask

    task automatic test_rotation();
        logic [1:0] va [8] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        logic [1:0] vb [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
        logic [1:0] ep [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(va[i], vb[i], 1'b0);
            n_cmp++; if (phase !== ep[i]) begin n_bad++; $display("FAIL rot_phase[%0d] got %0d want %0d", i, phase, ep[i]); end
        end
        n_cmp++; if (cycle_count !== 2'd1) begin n_bad++; $display("FAIL rot_count got %0d want 1", cycle_count); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rot_err got %0b want 0", err); end
    endtask

    task automatic test_first_sample();
        do_reset();
        step(2'b00, 2'b01, 1'b0);
        n_cmp++; if ({err, err_code} !== 4'b1100) begin n_bad++; $display("FAIL first_err got %b want 1100", {err, err_code}); end
        n_cmp++; if (phase !== 2'd3) begin n_bad++; $display("FAIL first_phase got %0d want 3", phase); end
    endtask

    task automatic test_skip_yellow();
        do_reset();
        step(2'b00, 2'b10, 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL skip_err got %0b want 1", err); end
        n_cmp++; if (err_code !== 3'b100) begin n_bad++; $display("FAIL skip_code got %b want 100", err_code); end
        n_cmp++; if (phase !== 2'd2) begin n_bad++; $display("FAIL skip_phase got %0d want 2", phase); end
    endtask

    task automatic test_priority();
        step(2'b00, 2'b10, 1'b1);
        n_cmp++; if ({err, err_code} !== 4'b0000) begin n_bad++; $display("FAIL prio_clr0 got %b want 0000", {err, err_code}); end
        step(2'b11, 2'b10, 1'b0);
        n_cmp++; if ({err, err_code} !== 4'b1001) begin n_bad++; $display("FAIL prio_bad got %b want 1001", {err, err_code}); end
        n_cmp++; if (phase !== 2'd2) begin n_bad++; $display("FAIL prio_hold got %0d want 2", phase); end
        step(2'b10, 2'b10, 1'b0);
        n_cmp++; if ({err, err_code} !== 4'b1001) begin n_bad++; $display("FAIL prio_sticky got %b want 1001", {err, err_code}); end
        step(2'b00, 2'b10, 1'b1);
        n_cmp++; if ({err, err_code} !== 4'b0000) begin n_bad++; $display("FAIL prio_clr got %b want 0000", {err, err_code}); end
    endtask

    task automatic test_clear_collision();
        step(2'b10, 2'b00, 1'b0);
        n_cmp++; if ({err, err_code} !== 4'b1100) begin n_bad++; $display("FAIL coll_setup got %b want 1100", {err, err_code}); end
        n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL coll_resync got %0d want 0", phase); end
        step(2'b00, 2'b00, 1'b1);
        n_cmp++; if ({err, err_code} !== 4'b1011) begin n_bad++; $display("FAIL coll_code got %b want 1011", {err, err_code}); end
        n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL coll_hold got %0d want 0", phase); end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(2'b10, 2'b00, 1'b0);
            n_cmp++; if (starve_b !== (k >= 16)) begin n_bad++; $display("FAIL starve_b[%0d] got %0b want %0b", k, starve_b, (k >= 16)); end
            n_cmp++; if (starve_a !== 1'b0) begin n_bad++; $display("FAIL starve_a[%0d] got %0b want 0", k, starve_a); end
        end
        step(2'b01, 2'b00, 1'b0);
        n_cmp++; if (starve_b !== 1'b1) begin n_bad++; $display("FAIL starve_b_yel got %0b want 1", starve_b); end
        step(2'b00, 2'b10, 1'b0);
        n_cmp++; if ({starve_a, starve_b} !== 2'b00) begin n_bad++; $display("FAIL starve_end got %b want 00", {starve_a, starve_b}); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL starve_err got %0b want 0", err); end
    endtask

    task automatic test_saturation_reset();
        logic [1:0] want;
        do_reset();
        for (int r = 1; r <= 5; r++) begin
            step(2'b01, 2'b00, 1'b0);
            step(2'b00, 2'b10, 1'b0);
            step(2'b00, 2'b01, 1'b0);
            step(2'b10, 2'b00, 1'b0);
            want = (r < 3) ? 2'(r) : 2'd3;
            n_cmp++; if (cycle_count !== want) begin n_bad++; $display("FAIL sat_count[%0d] got %0d want %0d", r, cycle_count, want); end
        end
        step(2'b01, 2'b00, 1'b0);
        n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL mid_phase got %0d want 1", phase); end
        step(2'b11, 2'b00, 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_err got %0b want 1", err); end
        #2;
        NOT_RESET = 1'b1;
        #1;
        n_cmp++; if ({phase, err, err_code, cycle_count, starve_a, starve_b} !== 10'd0) begin
            n_bad++; $display("FAIL async_reset got ph=%0d err=%0b code=%b cnt=%0d sa=%0b sb=%0b want all 0",
                              phase, err, err_code, cycle_count, starve_a, starve_b);
        end
        @(posedge clk);
        #1;
        NOT_RESET = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        NOT_RESET = 1'b1; La = 2'b10; Lb = 2'b00; clr_err = 1'b0;
        test_reset();
        test_rotation();
        test_first_sample();
        test_skip_yellow();
        test_priority();
        test_clear_collision();
        test_starvation();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the completed-cycle counter.
REQ-002 Parameter MAX_RED, default 16, sets the consecutive-red threshold for the starvation flags (valid range 2..255).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 NOT_RESET  input  1  reset, asynchronous, active-high.
REQ-005 La  input  2  street-A light code: green=2'b10, yellow=2'b01, red=2'b00, 2'b11 illegal.
REQ-006 Lb  input  2  street-B light code, same encoding as La.
REQ-007 clr_err  input  1  synchronous clear of err and err_code.
REQ-008 phase  output  2  tracked phase: 0=A_GREEN, 1=A_YELLOW, 2=B_GREEN, 3=B_YELLOW.
REQ-009 err  output  1  sticky protocol-violation flag.
REQ-010 err_code  output  3  code of the first violation since last clear/reset.
REQ-011 cycle_count  output  CNT_W  number of completed A->B->A rotations.
REQ-012 starve_a  output  1  La has been red for at least MAX_RED consecutive samples.
REQ-013 starve_b  output  1  Lb has been red for at least MAX_RED consecutive samples.

Function
REQ-014 The block SHALL sample {La,Lb} every clock and compare the sample against the registered phase; all outputs SHALL be registered, reflecting the sample one cycle later.
REQ-015 Legal patterns: {G,R}=A_GREEN, {Y,R}=A_YELLOW, {R,G}=B_GREEN, {R,Y}=B_YELLOW.
REQ-016 Allowed transitions: A_GREEN -> {G,R} stay or {Y,R}; A_YELLOW -> {R,G} only; B_GREEN -> {R,G} stay or {R,Y}; B_YELLOW -> {G,R} only.
REQ-017 On an allowed sample, phase SHALL take the phase of the sampled pattern.
REQ-018 On a legal but disallowed pattern, phase SHALL resynchronise to the sampled pattern's phase and a violation of code 3'b100 SHALL be raised.
REQ-019 On a non-legal pattern, phase SHALL hold and a violation SHALL be raised with priority: 3'b001 either code 2'b11; else 3'b010 both non-red; else 3'b011 both red.
REQ-020 err_code 3'b000 SHALL mean no violation.
REQ-021 On a violation with err=0, err SHALL set and err_code SHALL load the code.
REQ-022 While err=1, later violations SHALL NOT change err_code.
REQ-023 If clr_err=1 and there is no violation in the same cycle, err and err_code SHALL clear to 0.
REQ-024 If clr_err=1 and a violation occurs in the same cycle, err SHALL be 1 and err_code SHALL take the new code.
REQ-025 cycle_count SHALL increment by 1 on each allowed B_YELLOW -> A_GREEN transition, saturating at 2^CNT_W-1 (no wrap).
REQ-026 A red counter per street SHALL increment while the sampled code is 2'b00, saturate at MAX_RED, and clear to 0 on any non-red sample.
REQ-027 starve_x SHALL be 1 exactly when its red counter equals MAX_RED.
REQ-028 Red counters SHALL run regardless of violations.

Reset
REQ-029 While NOT_RESET=1: phase=0 (A_GREEN), err=0, err_code=0, cycle_count=0, red counters=0, starve_a=0, starve_b=0.
REQ-030 Reset asserted mid-operation SHALL take effect immediately (asynchronously), discarding in-flight state.
REQ-031 The first sample after reset release SHALL be checked against A_GREEN.

Verification
REQ-032 Legal rotation: reset, then {La,Lb} = 10/00 x3, 01/00, 00/10 x2, 00/01, 10/00 -> phase 0,0,0,1,2,2,3,0; cycle_count=1; err=0.
REQ-033 Skipped yellow: from A_GREEN drive 00/10 -> next cycle err=1, err_code=3'b100, phase=2.
REQ-034 Priority and stickiness: drive 11/10 -> err_code=3'b001; then drive 10/10 -> err_code stays 3'b001; clr_err=1 with legal input -> err=0, err_code=0.
REQ-035 Clear collision: err=1 with err_code=3'b100, drive clr_err=1 together with 00/00 -> err=1, err_code=3'b011.
REQ-036 Starvation: with MAX_RED=16, hold 10/00 for 20 cycles -> starve_b rises on the 16th sample's following edge and stays 1; starve_a=0; then 01/00 then 00/10 -> starve_b=0.
REQ-037 Saturation and reset: with CNT_W=2, run 5 legal rotations -> cycle_count=3; assert NOT_RESET mid-phase -> all outputs 0 immediately.
